// File: rtl/ecp_pkg.sv
// Shared constants for the elliptic-curve processor sequencer blocks.
package ecp_pkg;

    // Loop counter control states
    localparam logic [1:0] ECP_LC_IDLE = 2'd0;
    localparam logic [1:0] ECP_LC_RUN  = 2'd1;
    localparam logic [1:0] ECP_LC_DONE = 2'd2;

    // Count direction encoding
    localparam logic ECP_DIR_DOWN = 1'b0;
    localparam logic ECP_DIR_UP   = 1'b1;

endpackage

// File: rtl/ecp_loop_counter.sv
// Up/down loop counter for the EC processor sequencer.
// Produces the bit index for scalar-multiply loops and the word index for
// field-op loops. It has a programmable limit, a one-shot/wrap mode, a
// terminal-count flag and a done pulse.
module ecp_loop_counter
    import ecp_pkg::*;
#(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             enable,
    input  logic             up_down,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] count_next;
    logic             dir;
    logic             dir_next;
    logic             osh;
    logic             osh_next;
    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] lim_next;
    logic             at_term;
    logic             tc_next;

    // Next state, next count, config latch and the registered terminal flag
    always_comb begin
        state_next = state;
        count_next = count_out;
        dir_next   = dir;
        osh_next   = osh;
        lim_next   = lim;
        at_term    = (dir == ECP_DIR_UP) ? (count_out == lim) : (count_out == '0);

        case (state)
            ECP_LC_RUN: begin
                if (abort) begin
                    state_next = ECP_LC_IDLE;
                end else if (start) begin
                    count_next = load_val;
                    dir_next   = up_down;
                    osh_next   = oneshot;
                    lim_next   = limit;
                end else if (enable) begin
                    if (at_term) begin
                        if (osh) begin
                            state_next = ECP_LC_DONE;
                        end else if (dir == ECP_DIR_UP) begin
                            count_next = '0;
                        end else begin
                            count_next = lim;
                        end
                    end else if (dir == ECP_DIR_UP) begin
                        count_next = count_out + 1'b1;
                    end else begin
                        count_next = count_out - 1'b1;
                    end
                end
            end
            default: begin
                state_next = ECP_LC_IDLE;
                if (!abort && start) begin
                    state_next = ECP_LC_RUN;
                    count_next = load_val;
                    dir_next   = up_down;
                    osh_next   = oneshot;
                    lim_next   = limit;
                end
            end
        endcase

        tc_next = (state_next == ECP_LC_RUN) &&
                  ((dir_next == ECP_DIR_UP) ? (count_next == lim_next) : (count_next == '0));
    end

    // State, count, latched config and tc registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ECP_LC_IDLE;
            count_out <= RESET_VAL;
            dir       <= ECP_DIR_DOWN;
            osh       <= 1'b0;
            lim       <= '0;
            tc        <= 1'b0;
        end else begin
            state     <= state_next;
            count_out <= count_next;
            dir       <= dir_next;
            osh       <= osh_next;
            lim       <= lim_next;
            tc        <= tc_next;
        end
    end

    assign busy = (state == ECP_LC_RUN);
    assign done = (state == ECP_LC_DONE);

endmodule
